// File: rtl/data_sync_pkg.sv
// -----------------------------------------------------------------------------
// data_sync_pkg
//   Shared defaults for the enable-qualified multi-bit CDC synchronizer.
//   Only the control bit crosses through a flop chain. The data bus is
//   sampled once that control bit is stable in the destination domain.
// -----------------------------------------------------------------------------
package data_sync_pkg;

  // Flops in the enable synchronizer chain. Two is the usual MTBF minimum.
  localparam int unsigned DATA_SYNC_STAGES_DEFAULT    = 2;

  // Width of the crossing data bus.
  localparam int unsigned DATA_SYNC_BUS_WIDTH_DEFAULT = 8;

endpackage : data_sync_pkg

// File: rtl/data_sync_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
//   Single-bit multi-flop synchronizer. It can be reused for any level
//   signal that enters the CLK domain from an unrelated clock.
//
// Ports
//   CLK      in   destination clock, rising edge
//   RST      in   synchronous active-high reset; clears the whole chain
//   async_i  in   asynchronous level input
//   sync_o   out  synchronized level; NUM_STAGES edges of latency
// -----------------------------------------------------------------------------
module bit_sync
  import data_sync_pkg::*;
#(
  // Must be at least 2; the shift below needs a second stage to exist.
  parameter int unsigned NUM_STAGES = DATA_SYNC_STAGES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_i,
  output logic sync_o
);

  // Bit 0 samples the asynchronous input and may go metastable.
  // Every later bit gives one more cycle for it to resolve.
  logic [NUM_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // value its neighbour held before this edge; blocking would collapse the
  // chain into a single flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[NUM_STAGES-1];

endmodule : bit_sync

// File: rtl/data_sync.sv
// -----------------------------------------------------------------------------
// data_sync
//   Receive side of a multi-bit clock-domain crossing. The source holds
//   unsync_bus stable and raises bus_enable. Only bus_enable is synchronized.
//   A rising edge on the synchronized enable gives a one-cycle enable_pulse.
//   The same edge loads unsync_bus into the sync_bus register. unsync_bus is
//   quiet by then, so sampling the whole bus at once is safe.
//
// Ports
//   CLK           in   destination clock, rising edge
//   RST           in   synchronous active-high reset
//   bus_enable    in   asynchronous level, high while unsync_bus is valid
//   unsync_bus    in   asynchronous data, stable while bus_enable is high
//   enable_pulse  out  registered one-cycle strobe: sync_bus just updated
//   sync_bus      out  registered data, holds its value between loads
//
// Latency: bus_enable sampled high at edge k gives enable_pulse=1 and the
// new sync_bus after edge k+NUM_STAGES. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module data_sync
  import data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DATA_SYNC_STAGES_DEFAULT,
  parameter int unsigned BUS_WIDTH  = DATA_SYNC_BUS_WIDTH_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 bus_enable,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 enable_pulse,
  output logic [BUS_WIDTH-1:0] sync_bus
);

  logic                 sync_out;
  logic                 pulse_q;
  logic                 pulse_comb;
  logic                 enable_pulse_q;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic [BUS_WIDTH-1:0] sync_bus_d;

  // --- Enable synchronizer ---------------------------------------------------
  bit_sync #(
    .NUM_STAGES (NUM_STAGES)
  ) u_enable_sync (
    .CLK     (CLK),
    .RST     (RST),
    .async_i (bus_enable),
    .sync_o  (sync_out)
  );

  // --- Rising-edge detector --------------------------------------------------
  // pulse_q is the previous synchronized enable. A level held high gives
  // exactly one pulse. A falling edge gives none.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= sync_out;
    end
  end

  assign pulse_comb = sync_out & ~pulse_q;

  // --- Output mux ------------------------------------------------------------
  // The bus is loaded only on the detected edge. Between edges the register
  // recirculates its own value, so changes on unsync_bus are ignored.
  always_comb begin
    // NOTE: assigning a default first means every path writes sync_bus_d,
    // so no latch is inferred when the load condition is false.
    sync_bus_d = sync_bus_q;
    if (pulse_comb) begin
      sync_bus_d = unsync_bus;
    end
  end

  // --- Output registers ------------------------------------------------------
  // NOTE: the data register is reset as well. Downstream logic then sees a
  // defined all-zero bus before the first transfer, not power-up garbage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      enable_pulse_q <= 1'b0;
      sync_bus_q     <= '0;
    end else begin
      enable_pulse_q <= pulse_comb;
      sync_bus_q     <= sync_bus_d;
    end
  end

  assign enable_pulse = enable_pulse_q;
  assign sync_bus     = sync_bus_q;

endmodule : data_sync

// File: tb/tb_data_sync.sv
// -----------------------------------------------------------------------------
// tb_data_sync
//   Directed testbench for data_sync with default parameters: 2 stages,
//   8-bit bus, 20 ns clock. Inputs are driven and outputs sampled on the
//   falling edge. "Cycle n" is the falling edge after the n-th rising edge
//   that follows the stimulus change.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_sync;

  logic       CLK;
  logic       RST;
  logic       bus_enable;
  logic [7:0] unsync_bus;
  logic       enable_pulse;
  logic [7:0] sync_bus;

  int checks = 0;
  int errors = 0;

  data_sync dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus_enable   (bus_enable),
    .unsync_bus   (unsync_bus),
    .enable_pulse (enable_pulse),
    .sync_bus     (sync_bus)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Watches n falling edges. Counts high enable_pulse samples and the cycle
  // of the first one (0 if none). Makes no comparisons.
  task automatic watch_pulses(input int n, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      if (enable_pulse === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    bus_enable = 1'b1;
    unsync_bus = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      checks++;
      if (enable_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_pulse cycle %0d: got %b expected 0", c, enable_pulse);
      end
      checks++;
      if (sync_bus !== 8'h00) begin
        errors++;
        $display("FAIL reset_bus cycle %0d: got %h expected 00", c, sync_bus);
      end
    end
    // Release reset with the enable low, so the chain starts from idle.
    RST        = 1'b0;
    bus_enable = 1'b0;
    unsync_bus = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (enable_pulse !== 1'b0 || sync_bus !== 8'h00) begin
        errors++;
        $display("FAIL idle_after_reset: got pulse=%b bus=%h expected 0/00",
                 enable_pulse, sync_bus);
      end
    end
  endtask

  task automatic test_basic_load();
    int pulses, first;
    bus_enable = 1'b1;
    unsync_bus = 8'b1100_1100;
    watch_pulses(5, pulses, first);
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL basic_pulse_count: got %0d expected 1", pulses);
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL basic_latency: got cycle %0d expected 3", first);
    end
    checks++;
    if (sync_bus !== 8'hCC) begin
      errors++;
      $display("FAIL basic_data: got %h expected cc", sync_bus);
    end
  endtask

  task automatic test_hold_deassert();
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if (enable_pulse !== 1'b0 || sync_bus !== 8'hCC) begin
        errors++;
        $display("FAIL hold_high cycle %0d: got pulse=%b bus=%h expected 0/cc",
                 c, enable_pulse, sync_bus);
      end
    end
    bus_enable = 1'b0;
    unsync_bus = 8'h00;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (enable_pulse !== 1'b0 || sync_bus !== 8'hCC) begin
        errors++;
        $display("FAIL deassert cycle %0d: got pulse=%b bus=%h expected 0/cc",
                 c, enable_pulse, sync_bus);
      end
    end
  endtask

  task automatic test_second_transfer();
    int pulses, first;
    // Change the inputs 9 ns after the falling edge, 1 ns before the next
    // rising edge, which is the first edge to sample them.
    #9;
    bus_enable = 1'b1;
    unsync_bus = 8'b1101_1000;
    watch_pulses(6, pulses, first);
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL second_pulse_count: got %0d expected 1", pulses);
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL second_latency: got cycle %0d expected 3", first);
    end
    checks++;
    if (sync_bus !== 8'hD8) begin
      errors++;
      $display("FAIL second_data: got %h expected d8", sync_bus);
    end
  endtask

  task automatic test_stable_data();
    logic [7:0] pattern [4] = '{8'h55, 8'hAA, 8'h0F, 8'hFF};
    for (int c = 0; c < 4; c++) begin
      unsync_bus = pattern[c];
      @(negedge CLK);
      checks++;
      if (enable_pulse !== 1'b0 || sync_bus !== 8'hD8) begin
        errors++;
        $display("FAIL stable_data pattern %h: got pulse=%b bus=%h expected 0/d8",
                 pattern[c], enable_pulse, sync_bus);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int pulses, first;
    // Return to idle, then start a transfer.
    bus_enable = 1'b0;
    repeat (3) @(negedge CLK);
    bus_enable = 1'b1;
    unsync_bus = 8'h3C;
    repeat (2) @(negedge CLK);  // both stages now hold 1
    RST = 1'b1;                 // wins over the load due on the next edge
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (enable_pulse !== 1'b0 || sync_bus !== 8'h00) begin
        errors++;
        $display("FAIL mid_reset cycle %0d: got pulse=%b bus=%h expected 0/00",
                 c, enable_pulse, sync_bus);
      end
    end
    unsync_bus = 8'hA5;
    RST        = 1'b0;
    watch_pulses(6, pulses, first);
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL refill_pulse_count: got %0d expected 1", pulses);
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL refill_latency: got cycle %0d expected 3", first);
    end
    checks++;
    if (sync_bus !== 8'hA5) begin
      errors++;
      $display("FAIL refill_data: got %h expected a5", sync_bus);
    end
  endtask

  // Safety net: a hung run still ends, and reports itself.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_hold_deassert();
    test_second_transfer();
    test_stable_data();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_sync

// File: doc/data_sync.md
Name: data_sync

Overview:
- Multi-bit clock-domain-crossing synchronizer using the enable-qualified (MUX-recirculation) scheme.
- The source domain drives an unsynchronized data bus plus a level `bus_enable`. Only `bus_enable` passes through a multi-flop synchronizer.
- A rising-edge detector on the synchronized enable produces a one-cycle `enable_pulse` and loads the bus into a destination-domain register.
- Sits on the receive side of every multi-bit crossing, e.g. register-file or UART data into the system clock domain.

Parameters:
- NUM_STAGES, 2, number of flip-flops in the `bus_enable` synchronizer chain (legal ≥2).
- BUS_WIDTH, 8, width of `unsync_bus` and `sync_bus`.

Ports:
- CLK  input  1  destination-domain clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- bus_enable  input  1  asynchronous level; high while `unsync_bus` holds valid data.
- unsync_bus  input  BUS_WIDTH  asynchronous data; stable while `bus_enable` is high.
- enable_pulse  output  1  registered; one-CLK-cycle pulse when new data lands on `sync_bus`.
- sync_bus  output  BUS_WIDTH  registered synchronized data; holds its value between loads.

Behaviour:
- Reset: on a CLK rising edge with RST=1, clear to 0: all sync stages, the pulse-gen flop, `enable_pulse` and `sync_bus`. Reset overrides all other activity.
- Sync chain: `sync_ff[0] <= bus_enable`, then `sync_ff[i] <= sync_ff[i-1]`; `sync_out = sync_ff[NUM_STAGES-1]`.
- Pulse gen: `pulse_ff <= sync_out`; `pulse_comb = sync_out & ~pulse_ff`.
- Output regs: `enable_pulse <= pulse_comb`; `sync_bus <= pulse_comb ? unsync_bus : sync_bus`.
- Latency: `bus_enable` sampled high at edge k gives `enable_pulse`=1 and `sync_bus`=`unsync_bus` after edge k+NUM_STAGES (3rd edge for default). `enable_pulse` returns to 0 one edge later.
- Exactly one pulse per low→high transition of synchronized `bus_enable`. Holding `bus_enable` high for any number of cycles gives no further pulses.
- `bus_enable` falling: no pulse; `sync_bus` keeps its last value.
- Re-assertion after at least 1 low cycle (as seen by CLK): new pulse, new load.
- A `bus_enable` high shorter than one CLK period may be missed; the source must hold it ≥1 CLK period, plus `unsync_bus` stable until `enable_pulse`.
- `unsync_bus` changes while `pulse_comb`=0 have no effect on `sync_bus`.
- Reset mid-operation: all state clears. If `bus_enable` is still high after RST drops, the chain refills and a fresh pulse/load occurs NUM_STAGES+1 edges later.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package: `DATA_SYNC_STAGES_DEFAULT`=2, `DATA_SYNC_BUS_WIDTH_DEFAULT`=8.
- One sub-module: `bit_sync` (parameter NUM_STAGES; CLK, RST, async in, sync out), a single-bit synchronizer chain, reusable elsewhere.
- Pulse generator and output mux/register stay in data_sync.

Test Plan:
- Reset: hold RST=1 for 10 cycles with `bus_enable`=1, `unsync_bus`=8'hFF → `enable_pulse`=0, `sync_bus`=8'h00 throughout.
- Basic load: release RST, drive `bus_enable`=1, `unsync_bus`=8'b1100_1100 at a negedge → `enable_pulse`=1 for exactly one cycle after the 3rd rising edge, `sync_bus`=8'hCC from then on.
- Hold/deassert: keep `bus_enable`=1 for 4 cycles, then `bus_enable`=0, `unsync_bus`=8'h00 → no second pulse; `sync_bus` stays 8'hCC.
- Second transfer, async timing: after 1 low cycle, assert `bus_enable`=1 with `unsync_bus`=8'b1101_1000 9 ns after a negedge (20 ns clock) → a single pulse 3 edges after first sampling, `sync_bus`=8'hD8.
- Stable-data check: toggle `unsync_bus` while `bus_enable` is held high after the pulse → `sync_bus` unchanged.
- Reset mid-transfer: assert RST while the chain holds 1s → outputs clear to 0; after RST release with `bus_enable` still 1 → new pulse after 3 edges, current `unsync_bus` loaded.
